// File: rtl/cory_tpram_pipe.sv
// cory_tpram_pipe: two-port RAM with lane write mask, RL-cycle read pipe,
// self-clearing init after reset and sticky error flags.
// Ports: clk, reset (async, high); write port wen(low)/wmask/waddr/wdata;
// read port ren(low)/raddr -> rdata/rvalid; init_busy, err_ovf, err_busy.
// Macros: CORY_TPRAM_BYPASS_EN (same-address write->read forwarding),
// SIM (X checks, parameter check).
module cory_tpram_pipe #(
  parameter int A = 8,
  parameter int D = 32,
  parameter int W = 8,
  parameter int SIZE = 2**A,
  parameter int RL = 1,
  parameter int INIT = 1,
  parameter logic [D-1:0] INIT_VAL = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wen,
  input  logic [D/W-1:0] wmask,
  input  logic [A-1:0]   waddr,
  input  logic [D-1:0]   wdata,
  input  logic           ren,
  input  logic [A-1:0]   raddr,
  output logic [D-1:0]   rdata,
  output logic           rvalid,
  output logic           init_busy,
  output logic           err_ovf,
  output logic           err_busy
);

  localparam int N = D / W;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t         state_q;
  logic [A-1:0]   cnt_q;
  logic           init_busy_q;
  logic           err_ovf_q;
  logic           err_busy_q;

  logic [D-1:0]   mem_q [SIZE];

  logic [RL-1:0]  pv_q;
  logic [D-1:0]   pd_q [RL];

  logic           run;
  logic           w_in;
  logic           r_in;
  logic           wr_acc;
  logic           rd_acc;
  logic           mem_we;
  logic [A-1:0]   mem_wa;
  logic [D-1:0]   mem_wd;
  logic [N-1:0]   mem_wm;
  logic [D-1:0]   rd_word;

  assign run    = (state_q == S_RUN);
  assign w_in   = int'(waddr) < SIZE;
  assign r_in   = int'(raddr) < SIZE;
  assign wr_acc = run && !wen;
  assign rd_acc = run && !ren;

  // Clear sequencer owns the write port while not running.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = wdata;
    mem_wm = wmask;
    if (!run) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = INIT_VAL;
      mem_wm = '1;
    end else if (wr_acc && w_in) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < N; i++) begin
        if (mem_wm[i]) mem_q[mem_wa][i*W +: W] <= mem_wd[i*W +: W];
      end
    end
  end

  // Out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (r_in) begin
      rd_word = mem_q[raddr];
`ifdef CORY_TPRAM_BYPASS_EN
      if (wr_acc && w_in && waddr == raddr) begin
        for (int i = 0; i < N; i++) begin
          if (wmask[i]) rd_word[i*W +: W] = wdata[i*W +: W];
        end
      end
`endif
    end
  end

  // Data stages load only behind a valid so rdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= '0;
      for (int k = 0; k < RL; k++) pd_q[k] <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      if (rd_acc) pd_q[0] <= rd_word;
      for (int k = 1; k < RL; k++) begin
        pv_q[k] <= pv_q[k-1];
        if (pv_q[k-1]) pd_q[k] <= pd_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= (INIT != 0) ? S_CLEAR : S_RUN;
      cnt_q       <= '0;
      init_busy_q <= (INIT != 0);
      err_ovf_q   <= 1'b0;
      err_busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          if (!wen || !ren) err_busy_q <= 1'b1;
          if (cnt_q == A'(SIZE - 1)) begin
            state_q     <= S_RUN;
            init_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + A'(1);
          end
        end
        S_RUN: begin
          if ((!wen && !w_in) || (!ren && !r_in)) err_ovf_q <= 1'b1;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign rdata     = pd_q[RL-1];
  assign rvalid    = pv_q[RL-1];
  assign init_busy = init_busy_q;
  assign err_ovf   = err_ovf_q;
  assign err_busy  = err_busy_q;

`ifdef SIM
  int x_errs = 0;

  if (SIZE > 2**A) begin : g_size_chk
    initial begin
      $display("ERROR: %m SIZE=%0d exceeds 2**A=%0d", SIZE, 2**A);
      $finish;
    end
  end

  always @(posedge clk) begin
    if (!reset && wr_acc && $isunknown({waddr, wdata})) begin
      x_errs = x_errs + 1;
      $display("ERROR: %m @%0t X on write addr/data", $time);
    end
    if (!reset && rd_acc && $isunknown(raddr)) begin
      x_errs = x_errs + 1;
      $display("ERROR: %m @%0t X on read addr", $time);
    end
    if (x_errs > 100) $finish;
  end
`endif

endmodule

// File: tb/tb_cory_tpram_pipe.sv
// tb_cory_tpram_pipe: directed bench for cory_tpram_pipe with a read
// scoreboard (expected word + due cycle) drained by a monitor.
module tb_cory_tpram_pipe;

  localparam int A = 4;
  localparam int D = 32;
  localparam int W = 8;
  localparam int SIZE = 12;
  localparam int RL = 3;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wen = 1'b1;
  logic [3:0]    wmask = '0;
  logic [A-1:0]  waddr = '0;
  logic [D-1:0]  wdata = '0;
  logic          ren = 1'b1;
  logic [A-1:0]  raddr = '0;
  logic [D-1:0]  rdata;
  logic          rvalid;
  logic          init_busy;
  logic          err_ovf;
  logic          err_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  cory_tpram_pipe #(
    .A(A), .D(D), .W(W), .SIZE(SIZE), .RL(RL),
    .INIT(1), .INIT_VAL(IV)
  ) dut (
    .clk(clk), .reset(reset),
    .wen(wen), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid),
    .init_busy(init_busy), .err_ovf(err_ovf), .err_busy(err_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rvalid) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rvalid: unexpected pulse at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.data || cyc != e.due) begin
          fails++;
          $display("FAIL read: got %h at cycle %0d expected %h at %0d",
                   rdata, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic do_write(input logic [A-1:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    wen = 1'b0; waddr = a; wdata = d; wmask = m;
    @(negedge clk);
    wen = 1'b1;
  endtask

  task automatic do_read(input logic [A-1:0] a, input logic [31:0] d,
                         input bit push);
    exp_t e;
    ren = 1'b0; raddr = a;
    if (push) begin
      e.data = d;
      e.due = cyc + RL;
      sb.push_back(e);
    end
    @(negedge clk);
    ren = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  task automatic count_clear(input int start, output int n);
    n = start;
    while (init_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] coll;
`ifdef CORY_TPRAM_BYPASS_EN
    coll = 32'hFFFFFFFF;
`else
    coll = 32'h00000000;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_busy", err_busy, 0);
    chk("rst_init_busy", init_busy, 1);

    reset = 1'b0;
    count_clear(0, n);
    chk("clear_cycles", n, SIZE);
    chk("clear_err_busy", err_busy, 0);
    for (int i = 0; i < SIZE; i++) do_read(A'(i), IV, 1'b1);
    drain();

    do_write(5, 32'h12345678, 4'hF);
    for (int i = 0; i < 4; i++) do_read(5, 32'h12345678, 1'b1);
    drain();

    do_write(7, 32'h11223344, 4'hF);
    do_write(7, 32'hAABBCCDD, 4'b0101);
    do_read(7, 32'h11BB33DD, 1'b1);
    do_write(7, 32'h99999999, 4'h0);
    do_read(7, 32'h11BB33DD, 1'b1);
    drain();

    do_write(2, 32'h0, 4'hF);
    wen = 1'b0; waddr = 2; wdata = 32'hFFFFFFFF; wmask = 4'hF;
    do_read(2, coll, 1'b1);
    do_read(2, 32'hFFFFFFFF, 1'b1);
    drain();

    chk("ovf_before", err_ovf, 0);
    do_read(13, 32'h0, 1'b1);
    drain();
    chk("ovf_read", err_ovf, 1);
    do_write(14, 32'hDEADBEEF, 4'hF);
    do_read(5, 32'h12345678, 1'b1);
    drain();
    chk("ovf_sticky", err_ovf, 1);
    chk("busy_clean", err_busy, 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_init_busy", init_busy, 1);
    chk("mid_err_ovf", err_ovf, 0);
    chk("mid_err_busy", err_busy, 0);
    reset = 1'b0;
    do_write(3, 32'hDEADBEEF, 4'hF);
    do_read(3, 32'h0, 1'b0);
    count_clear(2, n);
    chk("reclear_cycles", n, SIZE);
    chk("busy_err", err_busy, 1);
    do_read(3, IV, 1'b1);
    do_read(5, IV, 1'b1);
    do_read(7, IV, 1'b1);
    drain();
    chk("busy_sticky", err_busy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cory_tpram_pipe.md
Name: cory_tpram_pipe

Overview:
Single-clock two-port RAM with per-lane write mask, configurable read latency, self-clearing initialisation and sticky error flags. It is the synthesisable-style successor to the simulation-only two-port memory model and is used as the storage core in buffers and tables that need deterministic read timing and a known post-reset memory state. One write port and one read port are each usable every cycle.

Parameters:
A, 8, address width
D, 32, data width; must be a multiple of W
W, 8, write-mask lane width; lanes N = D/W
SIZE, 2**A, number of words; must be <= 2**A, otherwise $display ERROR and $finish at time 0
RL, 1, read latency in cycles, legal 1..4
INIT, 1, 1 = clear memory after reset, 0 = no clear
INIT_VAL, 0, D-bit value written to every word during clear

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
wen  in  1  write enable, active-low
wmask  in  N  lane write enable, active-high, bit i covers wdata[i*W +: W]
waddr  in  A  write address
wdata  in  D  write data
ren  in  1  read enable, active-low
raddr  in  A  read address
rdata  out  D  read data
rvalid  out  1  rdata carries a read result this cycle
init_busy  out  1  clear in progress, requests ignored
err_ovf  out  1  sticky: address >= SIZE seen on an accepted access
err_busy  out  1  sticky: request issued while init_busy

Behaviour:
- Reset (async, while reset=1): rdata=0, rvalid=0, err_ovf=0, err_busy=0, read pipeline flushed, init_busy=1 if INIT=1 else 0, FSM to CLEAR (INIT=1) or RUN (INIT=0). Memory contents are not reset directly.
- FSM states: CLEAR, RUN.
- CLEAR: an A-bit counter starts at 0 and writes INIT_VAL to one word per cycle. When the counter reaches SIZE-1, that word is written and the FSM goes to RUN. This takes exactly SIZE cycles after reset deasserts. init_busy=1 throughout CLEAR and drops in the first RUN cycle.
- Reset asserted mid-CLEAR restarts the clear from address 0.
- During CLEAR, wen=0 or ren=0 is dropped: no memory change, no rvalid, err_busy set.
- Write (RUN, wen=0, waddr<SIZE): at posedge, lanes with wmask[i]=1 are updated; other lanes are kept. wmask=0 is a legal no-op write.
- Read (RUN, ren=0) at cycle t: memory is sampled at posedge t, then passes through RL-1 further registers. rdata is valid and rvalid=1 in cycle t+RL.
  - Back-to-back reads give one result per cycle.
  - rvalid is a one-cycle pulse per accepted read.
  - rdata holds its last value when rvalid=0.
- Out of range (address >= SIZE, only possible when SIZE<2**A):
  - Write is dropped and err_ovf is set.
  - Read still produces rvalid at t+RL, with rdata=0, and err_ovf is set.
- Same-cycle read and write to the same address: read-before-write, so rdata returns the old word unless CORY_TPRAM_BYPASS_EN is defined.
- err_ovf and err_busy clear only on reset.
- X checking under SIM, errors counted and printed with %m and $time as in the existing model:
  - On an accepted write, X on waddr or wdata is an error.
  - On an accepted read, X on raddr is an error.
  - More than 100 errors triggers $finish.

Optional Feature:
CORY_TPRAM_BYPASS_EN: when defined, a same-cycle read and write to the same in-range address returns the merged word at t+RL: new data on lanes with wmask=1, old data elsewhere. When undefined, the old word is returned and no forwarding mux is built. Writes to other addresses are never forwarded, in either case.

Test Plan:
- Clear: INIT=1, A=4, SIZE=16, INIT_VAL=32'hA5A5A5A5, release reset -> init_busy=1 for exactly 16 cycles; then reads of addresses 0..15 all return A5A5A5A5; err_busy=0.
- Latency: RL=3, write 32'h12345678 to addr 5, then ren=0 raddr=5 at cycle t -> rvalid=1 only at t+3, rdata=12345678; 4 back-to-back reads give 4 consecutive rvalid pulses.
- Mask: word 7 = 32'h11223344, write 32'hAABBCCDD with wmask=4'b0101 -> read returns 32'h11BB33DD.
- Collision: word 2 = 32'h0, same-cycle write 32'hFFFFFFFF (wmask=4'hF) and read of addr 2 -> rdata 32'h0 without the macro, 32'hFFFFFFFF with it; a following read returns FFFFFFFF in both builds.
- Range and busy: SIZE=12, A=4, read addr 13 -> rvalid=1, rdata=0, err_ovf=1 and stays set. Write during CLEAR -> err_busy=1 and the cleared value is intact.
- Reset mid-clear: assert reset at clear cycle 6 for 2 cycles -> init_busy stays 1 and the clear completes SIZE cycles after the second reset release.
